// File: rtl/sync2_pse.sv
// Multi-flop CDC synchronizer with rising/falling edge pulses on the synchronized level.
// Define SYNC2_PSE_REG_EDGE_EN to register pe/ne (one extra cycle of pulse latency).
module sync2_pse #(
  parameter int W = 1,
  parameter int R = 0,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] pe,
  output logic [W-1:0] ne
);

  localparam logic [W-1:0] RST_VAL = (R != 0) ? '1 : '0;

  (* ASYNC_REG = "TRUE" *) logic [W-1:0] s [N];
  logic [W-1:0] h;

  // h shares the reset value with the chain so reset release never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s <= '{default: RST_VAL};
      h <= RST_VAL;
    end else begin
      s[0] <= d;
      for (int unsigned k = 1; k < unsigned'(N); k++) begin
        s[k] <= s[k-1];
      end
      h <= q;
    end
  end

  assign q = s[N-1];

`ifdef SYNC2_PSE_REG_EDGE_EN
  logic [W-1:0] pe_r;
  logic [W-1:0] ne_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      pe_r <= '0;
      ne_r <= '0;
    end else begin
      pe_r <= q & ~h;
      ne_r <= ~q & h;
    end
  end

  assign pe = pe_r;
  assign ne = ne_r;
`else
  assign pe = q & ~h;
  assign ne = ~q & h;
`endif

endmodule

// File: tb/tb_sync2_pse.sv
// Directed bench for sync2_pse: table-driven N=2 vectors plus R=1 and N=3 reset sequences.
module tb_sync2_pse;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // u0: W=1 R=0 N=2, u4: W=4 R=0 N=2 (shared reset, table driven)
  logic       rst_a = 1'b1;
  logic       d0 = 1'b0;
  logic       q0, pe0, ne0;
  logic [3:0] d4 = '0;
  logic [3:0] q4, pe4, ne4;
  // u1: W=1 R=1 N=2
  logic       rst1 = 1'b1;
  logic       d1 = 1'b1;
  logic       q1, pe1, ne1;
  // u3: W=1 R=0 N=3
  logic       rst3 = 1'b1;
  logic       d3 = 1'b0;
  logic       q3, pe3, ne3;

  sync2_pse #(.W(1), .R(0), .N(2)) u0 (.clk(clk), .rst(rst_a), .d(d0), .q(q0), .pe(pe0), .ne(ne0));
  sync2_pse #(.W(4), .R(0), .N(2)) u4 (.clk(clk), .rst(rst_a), .d(d4), .q(q4), .pe(pe4), .ne(ne4));
  sync2_pse #(.W(1), .R(1), .N(2)) u1 (.clk(clk), .rst(rst1), .d(d1), .q(q1), .pe(pe1), .ne(ne1));
  sync2_pse #(.W(1), .R(0), .N(3)) u3 (.clk(clk), .rst(rst3), .d(d3), .q(q3), .pe(pe3), .ne(ne3));

  typedef struct packed {
    logic       rst;
    logic       d0;
    logic [3:0] d4;
    logic       q0;
    logic       pe0;
    logic       ne0;
    logic [3:0] q4;
    logic [3:0] pe4;
    logic [3:0] ne4;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  task automatic chk(input string name, input int step, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", name, step, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input int step,
                      input logic qa, input logic pa, input logic na,
                      input logic qe, input logic pex, input logic nex);
    chk({tag, ".q"},  step, {3'b0, qa}, {3'b0, qe});
    chk({tag, ".pe"}, step, {3'b0, pa}, {3'b0, pex});
    chk({tag, ".ne"}, step, {3'b0, na}, {3'b0, nex});
  endtask

  initial begin
    // rst, d0, d4 | q0 pe0 ne0 | q4 pe4 ne4   (expected values after the edge)
    tbl[0]  = '{1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    tbl[3]  = '{1'b0, 1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    tbl[4]  = '{1'b0, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 4'b1010, 4'b1010, 4'b0000};
    tbl[5]  = '{1'b0, 1'b1, 4'b0110, 1'b1, 1'b1, 1'b0, 4'b1010, 4'b0000, 4'b0000};
    tbl[6]  = '{1'b0, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 4'b0110, 4'b0100, 4'b1000};
    tbl[7]  = '{1'b0, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 4'b0110, 4'b0000, 4'b0000};
    tbl[8]  = '{1'b0, 1'b1, 4'b0101, 1'b1, 1'b0, 1'b0, 4'b0110, 4'b0000, 4'b0000};
    tbl[9]  = '{1'b0, 1'b0, 4'b0101, 1'b1, 1'b0, 1'b0, 4'b0101, 4'b0001, 4'b0010};
    tbl[10] = '{1'b0, 1'b0, 4'b1010, 1'b0, 1'b0, 1'b1, 4'b0101, 4'b0000, 4'b0000};
    tbl[11] = '{1'b0, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 4'b1010, 4'b1010, 4'b0101};
    tbl[12] = '{1'b0, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 4'b0101, 4'b0101, 4'b1010};
    tbl[13] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b1010, 4'b1010, 4'b0101};
    tbl[14] = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b1010};
    tbl[15] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    tbl[16] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    tbl[17] = '{1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    tbl[18] = '{1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    tbl[19] = '{1'b0, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 4'b1111, 4'b1111, 4'b0000};
    tbl[20] = '{1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    tbl[21] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000};

    for (int i = 0; i < NV; i++) begin
      rst_a = tbl[i].rst;
      d0    = tbl[i].d0;
      d4    = tbl[i].d4;
      tick();
      chk3("w1", i + 1, q0, pe0, ne0, tbl[i].q0, tbl[i].pe0, tbl[i].ne0);
      chk("w4.q",  i + 1, q4,  tbl[i].q4);
      chk("w4.pe", i + 1, pe4, tbl[i].pe4);
      chk("w4.ne", i + 1, ne4, tbl[i].ne4);
    end

    // R=1: reset with d=1, release with d held high, then a real fall
    rst1 = 1'b1; d1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk3("r1.rst", i, q1, pe1, ne1, 1'b1, 1'b0, 1'b0);
    end
    rst1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk3("r1.hold", i, q1, pe1, ne1, 1'b1, 1'b0, 1'b0);
    end
    d1 = 1'b0;
    tick();
    chk3("r1.fall0", 0, q1, pe1, ne1, 1'b1, 1'b0, 1'b0);
    tick();
    chk3("r1.fall1", 1, q1, pe1, ne1, 1'b0, 1'b0, 1'b1);
    tick();
    chk3("r1.fall2", 2, q1, pe1, ne1, 1'b0, 1'b0, 1'b0);

    // N=3: reset lands on the edge where q would have risen
    rst3 = 1'b1; d3 = 1'b0;
    tick();
    chk3("n3.rst", 0, q3, pe3, ne3, 1'b0, 1'b0, 1'b0);
    rst3 = 1'b0; d3 = 1'b1;
    tick();
    chk3("n3.lat", 1, q3, pe3, ne3, 1'b0, 1'b0, 1'b0);
    tick();
    chk3("n3.lat", 2, q3, pe3, ne3, 1'b0, 1'b0, 1'b0);
    rst3 = 1'b1;
    tick();
    chk3("n3.midrst", 3, q3, pe3, ne3, 1'b0, 1'b0, 1'b0);
    rst3 = 1'b0;
    tick();
    chk3("n3.rel", 4, q3, pe3, ne3, 1'b0, 1'b0, 1'b0);
    tick();
    chk3("n3.rel", 5, q3, pe3, ne3, 1'b0, 1'b0, 1'b0);
    tick();
    chk3("n3.rise", 6, q3, pe3, ne3, 1'b1, 1'b1, 1'b0);
    for (int i = 7; i < 10; i++) begin
      tick();
      chk3("n3.held", i, q3, pe3, ne3, 1'b1, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
